// File: rtl/spi_reg_pkg.sv
// Shared constants, frame geometry and FSM state encoding for the SPI register bank.
package spi_reg_pkg;

    localparam int unsigned SPI_ADDR_W = 8;
    localparam int unsigned SPI_DATA_W = 8;
    localparam int unsigned FRAME_W    = SPI_ADDR_W + SPI_DATA_W;
    localparam int unsigned READ_FLAG  = SPI_ADDR_W - 1;

    localparam int unsigned REG_LED = 7;
    localparam int unsigned REG_MUX = 8;
    localparam int unsigned REG_DAC = 9;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SHIFT_ADDR = 3'd1,
        SHIFT_DATA = 3'd2,
        DONE       = 3'd3,
        OVERRUN    = 3'd4
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin with registered rise/fall pulses.
// level, rise and fall all change on the same clk edge, three clocks after the pin.
module spi_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync  <= 2'b00;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync  <= {sync[0], din};
            level <= sync[1];
            rise  <= sync[1] & ~level;
            fall  <= ~sync[1] & level;
        end
    end

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-1 slave register bank with peripheral CS/MISO pass-through router.
// Build option: define SPI_REG_READBACK_EN to shift register contents out on read frames.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int unsigned ADDR_W     = SPI_ADDR_W,
    parameter int unsigned DATA_W     = SPI_DATA_W,
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned NUM_PERIPH = 8,
    parameter int unsigned MUX_ADDR   = REG_MUX
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         spi_clk,
    input  logic                         spi_cs,
    input  logic                         spi_special,
    input  logic                         spi_mosi,
    output logic                         spi_miso,
    output logic [NUM_PERIPH-1:0]        periph_cs,
    input  logic [NUM_PERIPH-1:0]        periph_miso,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic [7:0]                   frame_err
);

    localparam int unsigned FRM_W = ADDR_W + DATA_W;
    localparam int unsigned IDX_W = ADDR_W - 1;
    localparam int unsigned CNT_W = $clog2(FRM_W + 2);

    // synchronised pin views
    logic sclk_rise, sclk_fall, unused_sclk_lvl;
    logic cs_rise, cs_fall, unused_cs_lvl;
    logic spec_lvl, spec_rise, unused_spec_fall;
    logic [2:0] mosi_sync;
    logic mosi;

    spi_sync_edge u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spi_clk),
        .level (unused_sclk_lvl),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge u_sync_cs (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spi_cs),
        .level (unused_cs_lvl),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_sync_edge u_sync_spec (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spi_special),
        .level (spec_lvl),
        .rise  (spec_rise),
        .fall  (unused_spec_fall)
    );

    // MOSI gets one extra flop so it lines up with the edge pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mosi_sync <= 3'b000;
        end else begin
            mosi_sync <= {mosi_sync[1:0], spi_mosi};
        end
    end

    assign mosi = mosi_sync[2];

    state_t state, state_next, state_shift;
    logic [CNT_W-1:0] cnt;
    logic [FRM_W-1:0] rx_shift;
    logic [7:0] err_q;
    logic [DATA_W-1:0] regs [NUM_REGS];

    logic             shift_c;
    logic             start_c;
    logic             latch_c;
    logic             abort_c;
    logic             err_c;
    logic             commit_c;
    logic [CNT_W-1:0] cnt_eff_c;
    logic [FRM_W-1:0] rx_eff_c;

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next state: apply this clk's bit first, then the cs/special events
    always_comb begin
        state_shift = state;
        if (sclk_fall) begin
            case (state)
                SHIFT_ADDR: if (cnt == CNT_W'(ADDR_W - 1)) state_shift = SHIFT_DATA;
                SHIFT_DATA: if (cnt == CNT_W'(FRM_W - 1))  state_shift = DONE;
                DONE:       state_shift = OVERRUN;
                default:    state_shift = state;
            endcase
        end
        state_next = state_shift;
        if ((state != IDLE) && spec_rise) begin
            state_next = IDLE;
        end else if (cs_rise) begin
            state_next = IDLE;
        end else if ((state == IDLE) && cs_fall && !spec_lvl) begin
            state_next = SHIFT_ADDR;
        end
    end

    // control strobes and post-shift datapath views
    always_comb begin
        shift_c   = sclk_fall && (state != IDLE);
        start_c   = (state == IDLE) && cs_fall && !spec_lvl;
        latch_c   = shift_c && (state == SHIFT_ADDR) && (state_shift == SHIFT_DATA);
        abort_c   = (state != IDLE) && spec_rise;
        cnt_eff_c = cnt;
        rx_eff_c  = rx_shift;
        if (shift_c) begin
            cnt_eff_c = (cnt == '1) ? cnt : cnt + CNT_W'(1);
            rx_eff_c  = {rx_shift[FRM_W-2:0], mosi};
        end
        err_c    = abort_c || (cs_rise && ((state_shift == SHIFT_ADDR) ||
                                           (state_shift == SHIFT_DATA) ||
                                           (state_shift == OVERRUN)));
        commit_c = !abort_c && cs_rise && (state_shift == DONE) &&
                   (cnt_eff_c == CNT_W'(FRM_W)) && !rx_eff_c[FRM_W-1];
    end

    // frame datapath, error counter and register file
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            rx_shift <= '0;
            err_q    <= 8'h00;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            cnt      <= start_c ? '0 : cnt_eff_c;
            rx_shift <= rx_eff_c;
            if (err_c && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'h01;
            end
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (commit_c && (rx_eff_c[FRM_W-2:DATA_W] == IDX_W'(i))) begin
                    regs[i] <= rx_eff_c[DATA_W-1:0];
                end
            end
        end
    end

    logic bank_miso;

`ifdef SPI_REG_READBACK_EN
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rd_val_c;
    logic              miso_q;

    // out-of-range index reads as zero
    always_comb begin
        rd_val_c = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rx_eff_c[ADDR_W-2:0] == IDX_W'(i)) begin
                rd_val_c = regs[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_shift <= '0;
            miso_q   <= 1'b0;
        end else if (state == IDLE) begin
            tx_shift <= '0;
            miso_q   <= 1'b0;
        end else if (latch_c) begin
            tx_shift <= rx_eff_c[ADDR_W-1] ? rd_val_c : '0;
        end else if (sclk_rise && (state == SHIFT_DATA)) begin
            miso_q   <= tx_shift[DATA_W-1];
            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
        end
    end

    assign bank_miso = miso_q;
`else
    logic unused_readback;
    assign unused_readback = sclk_rise | latch_c;
    assign bank_miso       = 1'b0;
`endif

    // pass-through router, purely combinational from the raw pins
    logic [NUM_PERIPH-1:0] mux;

    always_comb begin
        mux = regs[MUX_ADDR][NUM_PERIPH-1:0];
        if (spi_special) begin
            periph_cs = ~(mux & {NUM_PERIPH{~spi_cs}});
            spi_miso  = |(mux & periph_miso);
        end else begin
            periph_cs = '1;
            spi_miso  = bank_miso;
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = regs[i];
        end
    end

    assign frame_err = err_q;

endmodule
